// File: rtl/load_store_unit.sv
// Memory-access stage: drives the data-memory handshake, lane-aligns stores,
// extends load data for writeback and flags misaligned or timed-out accesses.
module load_store_unit #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        access_fault,
  output logic        stall
);

  // state | meaning
  // IDLE  | ready to accept an operation
  // REQ   | memory request outstanding, counting wait cycles
  // WB    | load result presented to writeback for one cycle
  // FAULT | misaligned, illegal or timed-out access reported for one cycle
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] WB    = 2'd2;
  localparam logic [1:0] FAULT = 2'd3;

  localparam logic [7:0] LAST_WAIT = 8'(WAIT_LIMIT - 1);

  logic [1:0]  state;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q;
  logic [7:0]  wait_cnt;
  logic [31:0] wb_data_q;

  logic        legal;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] shifted;
  logic [31:0] load_val;

  always_comb begin
    legal = 1'b0;
    case (funct3)
      3'b000, 3'b100: legal = 1'b1;
      3'b001, 3'b101: legal = ~alu_result[0];
      3'b010:         legal = (alu_result[1:0] == 2'b00);
      default:        legal = 1'b0;
    endcase
    // Unsigned variants only exist for loads.
    if (mem_write && funct3[2])
      legal = 1'b0;
  end

  always_comb begin
    be    = 4'b1111;
    wdata = data_q;
    case (f3_q[1:0])
      2'b00: begin
        be    = 4'b0001 << addr_q[1:0];
        wdata = {4{data_q[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << {addr_q[1], 1'b0};
        wdata = {2{data_q[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = data_q;
      end
    endcase
    if (!we_q)
      wdata = 32'd0;
  end

  always_comb begin
    shifted = mem_rdata >> {addr_q[1:0], 3'b000};
    case (f3_q)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {24'd0, shifted[7:0]};
      3'b101:  load_val = {16'd0, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      addr_q    <= 32'd0;
      data_q    <= 32'd0;
      we_q      <= 1'b0;
      f3_q      <= 3'd0;
      rd_q      <= 5'd0;
      wait_cnt  <= 8'd0;
      wb_data_q <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q   <= alu_result;
            data_q   <= store_data;
            we_q     <= mem_write;
            f3_q     <= funct3;
            rd_q     <= rd_in;
            wait_cnt <= 8'd0;
            state    <= legal ? REQ : FAULT;
          end
        end
        REQ: begin
          // An ack on the final allowed cycle wins over the timeout.
          if (mem_ack) begin
            if (!we_q) begin
              wb_data_q <= load_val;
              state     <= WB;
            end else begin
              state <= IDLE;
            end
          end else if (wait_cnt == LAST_WAIT) begin
            state <= FAULT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        WB:      state <= IDLE;
        FAULT:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready    = (state == IDLE);
  assign stall        = ~req_ready;
  assign mem_req      = (state == REQ);
  assign mem_we       = mem_req & we_q;
  assign mem_addr     = mem_req ? {addr_q[31:2], 2'b00} : 32'd0;
  assign mem_be       = mem_req ? be : 4'd0;
  assign mem_wdata    = mem_req ? wdata : 32'd0;
  assign wb_valid     = (state == WB);
  assign wb_rd        = rd_q;
  assign wb_data      = wb_data_q;
  assign access_fault = (state == FAULT);

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage of the execute pipeline. It sits directly downstream of the ALU and takes the ALU `Result` as the effective address for loads and stores. It runs a request/acknowledge handshake with the data memory, generates byte lanes and aligned write data, and sign- or zero-extends load data. Results go to the writeback stage, and misaligned or timed-out accesses are flagged as faults.

## Interface
- `WAIT_LIMIT`, default 15: maximum number of cycles spent in `REQ` waiting for `mem_ack` before the access is abandoned. Range 1–255.
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `reset`  in  1  — asynchronous, active-high.
- `req_valid`  in  1  — a memory operation is presented.
- `req_ready`  out  1  — the unit can accept an operation; high only in `IDLE`.
- `alu_result`  in  32  — effective address from the ALU.
- `store_data`  in  32  — rs2 value, used for stores.
- `mem_write`  in  1  — 1 = store, 0 = load.
- `funct3`  in  3  — size and signedness: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- `rd_in`  in  5  — destination register of a load.
- `mem_req`  out  1  — memory request, held until acknowledged.
- `mem_we`  out  1  — write strobe.
- `mem_addr`  out  32  — word-aligned address `{addr[31:2],2'b00}`.
- `mem_wdata`  out  32  — lane-replicated store data.
- `mem_be`  out  4  — byte enables.
- `mem_ack`  in  1  — memory completion; read data is valid in the same cycle.
- `mem_rdata`  in  32  — read word.
- `wb_valid`  out  1  — one-cycle pulse; load result is valid.
- `wb_rd`  out  5  — destination register.
- `wb_data`  out  32  — extended load data.
- `access_fault`  out  1  — one-cycle pulse on a misaligned access, illegal `funct3`, or timeout.
- `stall`  out  1  — equals `~req_ready`, for upstream hazard logic.

## Operation
- FSM states: `IDLE`, `REQ`, `WB`, `FAULT`.
- **Accept:** on a `req_valid && req_ready` edge, register address, data, `mem_write`, `funct3` and `rd_in`.
  - If the access is legal, go to `REQ`.
  - Otherwise go to `FAULT` and issue no memory request.
- **Legality:**
  - Halfword requires `addr[0]=0`.
  - Word requires `addr[1:0]=00`.
  - Loads accept `funct3` 000/001/010/100/101.
  - Stores accept `funct3` 000/001/010.
  - Anything else is illegal.
- **Store lanes:**
  - sb: `mem_be = 4'b0001<<addr[1:0]`, `mem_wdata = {4{d[7:0]}}`.
  - sh: `mem_be = 4'b0011<<{addr[1],1'b0}`, `mem_wdata = {2{d[15:0]}}`.
  - sw: `mem_be = 1111`, `mem_wdata = d`.
- **Loads:** `mem_be` is derived the same way, `mem_we=0`, `mem_wdata=0`.
- **Load extract:**
  - Shift `mem_rdata` right by `8*addr[1:0]`.
  - Take the low byte or halfword.
  - Sign-extend for b/h; zero-extend for bu/hu. Word passes unchanged.
- **`REQ`:**
  - `mem_req=1` with stable address, strobes and data.
  - A wait counter starts at 0 and increments each cycle without ack.
  - On `mem_ack` for a load: capture extracted data and go to `WB`.
  - On `mem_ack` for a store: go to `IDLE`.
  - If the counter reaches `WAIT_LIMIT` without ack: go to `FAULT`.
- **`WB`:** `wb_valid=1` for one cycle, then `IDLE`.
- **`FAULT`:** `access_fault=1` for one cycle, then `IDLE`. No writeback.
- `mem_ack` outside `REQ` is ignored.
- `req_valid` while busy is ignored; upstream must hold it until accepted.

## Timing
- **Reset values:**
  - state `IDLE`, `req_ready=1`.
  - `mem_req`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata` all 0.
  - `wb_valid`, `wb_rd`, `wb_data`, `access_fault` all 0; `stall=0`.
- All outputs are registered or decoded from state and registered fields. There is no combinational path from inputs to outputs.
- **Load with zero wait states:**
  - accept at edge 0;
  - `mem_req` high in cycle 1, ack sampled at edge 1;
  - `wb_valid` in cycle 2;
  - `req_ready` in cycle 3.
  - Each wait cycle adds 1.
- **Store:** `mem_req` in cycle 1; `req_ready` in cycle 2 when ack arrives at once.
- **Fault on accept:** `access_fault` in cycle 1, `req_ready` in cycle 2, and `mem_req` never rises.
- **Timeout:** `mem_req` is high for exactly `WAIT_LIMIT` cycles, then `access_fault` pulses in the next cycle.
- **Ack on the last allowed cycle** counts as success, not a fault.
- **Reset mid-`REQ`:** `mem_req` and all outputs drop immediately (asynchronously). No `wb_valid` or fault is produced afterward.
- Outputs are held stable while in `REQ`.

## Test plan
- **sw:** `addr=0x100`, data `0xDEADBEEF`, ack in cycle 1 → `mem_addr=0x100`, `mem_be=1111`, `mem_wdata=0xDEADBEEF`, `mem_we=1`, no `wb_valid`, `req_ready` back in cycle 2.
- **sb then lb:**
  - sb at `0x103` with data `0x80` → `mem_be=1000`, `mem_wdata=0x80808080`.
  - lb at `0x103` with `rdata=0x80123456` → `wb_data=0xFFFFFF80` in cycle 2, `wb_rd` equals `rd_in`.
- **lhu/lh:** `addr=0x102`, `rdata=0xBEEF1234`; lhu → `0x0000BEEF`, lh → `0xFFFFBEEF`; `mem_be=1100`.
- **Misaligned and illegal:**
  - lw at `0x101` → `access_fault` in cycle 1, `mem_req` never asserted.
  - sh at `0x0FF` → same.
  - Load with `funct3=011` → same.
- **Timeout:** `WAIT_LIMIT=4`, no ack → `mem_req` high exactly 4 cycles, then `access_fault`. Repeat with ack in the 4th cycle → `wb_valid`, no fault.
- **Reset and busy:**
  - Assert `reset` during cycle 2 of `REQ` → `mem_req=0` immediately; after release, `req_ready=1` and no spurious `wb_valid`.
  - A `req_valid` pulse while `stall=1` is not accepted.
